trail_grid: RTL and testbench



---
 rtl/trail_grid.sv | 151 +++++++++++++++
 tb/tb_trail_grid.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_grid.sv
// Light-cycle trail occupancy grid: 80x60 cells of 8x8 pixels, collision detection and per-pixel trail colour.
// Step check takes 2 cycles after the step edge; the display path is a 2-cycle registered read.
module trail_grid #(
  parameter int GRID_W      = 80,
  parameter int GRID_H      = 60,
  parameter int CELL_SHIFT  = 3,
  parameter int FIELD_MIN_X = 16,
  parameter int FIELD_MAX_X = 623,
  parameter int FIELD_MIN_Y = 16,
  parameter int FIELD_MAX_Y = 463,
  parameter int TRAIL_R     = 255,
  parameter int TRAIL_G     = 128,
  parameter int TRAIL_B     = 0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic [9:0] head_x,
  input  logic [9:0] head_y,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic       busy,
  output logic       collision,
  output logic [7:0] trail_r,
  output logic [7:0] trail_g,
  output logic [7:0] trail_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int          CELLS     = GRID_W * GRID_H;
  localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);
  localparam logic [9:0]  MIN_X     = 10'(FIELD_MIN_X);
  localparam logic [9:0]  MAX_X     = 10'(FIELD_MAX_X);
  localparam logic [9:0]  MIN_Y     = 10'(FIELD_MIN_Y);
  localparam logic [9:0]  MAX_Y     = 10'(FIELD_MAX_Y);
  localparam logic [9:0]  SCREEN_W  = 10'(GRID_W << CELL_SHIFT);
  localparam logic [9:0]  SCREEN_H  = 10'(GRID_H << CELL_SHIFT);

  // Row * 80 built from two shifts instead of a multiplier.
  function automatic logic [12:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
    logic [12:0] row;
    logic [12:0] col;
    row = 13'(y >> CELL_SHIFT);
    col = 13'(x >> CELL_SHIFT);
    return (row << 6) + (row << 4) + col;
  endfunction

  logic        mem [CELLS];
  logic [1:0]  state;
  logic [12:0] clear_addr;
  logic [12:0] head_addr;
  logic        rd_b;
  logic        rd_a;
  logic        disp_vld;
  logic        disp_vld_q;
  logic [12:0] disp_addr;
  logic        head_out;
  logic        we_b;
  logic [12:0] wa_b;
  logic        wd_b;

  assign busy     = (state != S_IDLE);
  assign head_out = (head_x < MIN_X) || (head_x > MAX_X) ||
                    (head_y < MIN_Y) || (head_y > MAX_Y);
  assign disp_vld  = (next_x < SCREEN_W) && (next_y < SCREEN_H);
  assign disp_addr = disp_vld ? cell_addr(next_x, next_y) : 13'd0;

  // Port B write: sweep zeros in CLEAR, mark the cell in WRITE unless aborted or occupied.
  always_comb begin
    we_b = 1'b0;
    wa_b = head_addr;
    wd_b = 1'b0;
    if (!reset && !clear) begin
      if (state == S_CLEAR) begin
        we_b = 1'b1;
        wa_b = clear_addr;
      end else if (state == S_WRITE && !rd_b) begin
        we_b = 1'b1;
        wd_b = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (we_b) mem[wa_b] <= wd_b;
    rd_b <= mem[head_addr];
    rd_a <= mem[disp_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      state      <= S_CLEAR;
      clear_addr <= 13'd0;
      collision  <= 1'b0;
      head_addr  <= 13'd0;
    end else begin
      case (state)
        S_CLEAR: begin
          collision <= 1'b0;
          if (clear_addr == LAST_ADDR) begin
            state <= S_IDLE;
          end else begin
            clear_addr <= clear_addr + 13'd1;
          end
        end
        S_IDLE: begin
          if (step && !collision) begin
            head_addr <= cell_addr(head_x, head_y);
            if (head_out) begin
              collision <= 1'b1;
            end else begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: state <= S_WRITE;
        S_WRITE: begin
          if (rd_b) collision <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      disp_vld_q <= 1'b0;
      trail_r    <= 8'd0;
      trail_g    <= 8'd0;
      trail_b    <= 8'd0;
    end else begin
      disp_vld_q <= disp_vld;
      if (clear || state == S_CLEAR || !disp_vld_q || !rd_a) begin
        trail_r <= 8'd0;
        trail_g <= 8'd0;
        trail_b <= 8'd0;
      end else begin
        trail_r <= 8'(TRAIL_R);
        trail_g <= 8'(TRAIL_G);
        trail_b <= 8'(TRAIL_B);
      end
    end
  end

endmodule

// File: tb/tb_trail_grid.sv
// Directed bench for trail_grid: sweep timing, cell marking, collisions, clear and step-ignore cases.
module tb_trail_grid;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       step = 1'b0;
  logic [9:0] head_x = 10'd0;
  logic [9:0] head_y = 10'd0;
  logic [9:0] next_x = 10'd0;
  logic [9:0] next_y = 10'd0;
  logic       busy;
  logic       collision;
  logic [7:0] trail_r;
  logic [7:0] trail_g;
  logic [7:0] trail_b;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] TRAIL = {8'd255, 8'd128, 8'd0};
  localparam logic [23:0] BLACK = 24'd0;

  always #10 CLOCK_50 = ~CLOCK_50;

  trail_grid dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (clear),
    .step     (step),
    .head_x   (head_x),
    .head_y   (head_y),
    .next_x   (next_x),
    .next_y   (next_y),
    .busy     (busy),
    .collision(collision),
    .trail_r  (trail_r),
    .trail_g  (trail_g),
    .trail_b  (trail_b)
  );

  task automatic do_step(input logic [9:0] x, input logic [9:0] y);
    head_x = x;
    head_y = y;
    step   = 1'b1;
    @(negedge CLOCK_50);
    step   = 1'b0;
  endtask

  task automatic read_pixel(input logic [9:0] x, input logic [9:0] y, output logic [23:0] rgb);
    next_x = x;
    next_y = y;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rgb = {trail_r, trail_g, trail_b};
  endtask

  // Counts consecutive busy cycles from the current negedge; also flags bad outputs during the sweep.
  task automatic wait_sweep(output int n, output int bad);
    n = 0;
    bad = 0;
    for (int i = 0; i < 6000; i++) begin
      if (!busy) break;
      n++;
      if (collision !== 1'b0 || {trail_r, trail_g, trail_b} !== BLACK) bad++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic pulse_clear_and_sweep(input string name);
    int n;
    int bad;
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    wait_sweep(n, bad);
    checks++;
    if (n !== 4800) begin
      errors++;
      $display("FAIL %s_sweep_len busy_cycles=%0d expected=4800", name, n);
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1 || collision !== 1'b0 || {trail_r, trail_g, trail_b} !== BLACK) begin
      errors++;
      $display("FAIL reset_state busy=%b collision=%b trail=%h expected busy=1 collision=0 trail=0",
               busy, collision, {trail_r, trail_g, trail_b});
    end
    reset = 1'b0;
    wait_sweep(n, bad);
    checks++;
    if (n !== 4800) begin
      errors++;
      $display("FAIL reset_sweep_len busy_cycles=%0d expected=4800", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_sweep_outputs bad_cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_write();
    logic [23:0] rgb;
    int bad;
    do_step(10'd216, 10'd240);
    checks++;
    if (busy !== 1'b1 || collision !== 1'b0) begin
      errors++;
      $display("FAIL write_edge_n busy=%b collision=%b expected busy=1 collision=0", busy, collision);
    end
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_edge_n1 busy=%b expected=1", busy);
    end
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL write_edge_n2 busy=%b collision=%b expected busy=0 collision=0", busy, collision);
    end
    bad = 0;
    for (int y = 240; y < 248; y++) begin
      for (int x = 216; x < 224; x++) begin
        read_pixel(10'(x), 10'(y), rgb);
        if (rgb !== TRAIL) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL write_cell_scan bad_pixels=%0d expected=0", bad);
    end
    read_pixel(10'd224, 10'd240, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL write_right_neighbour trail=%h expected=%h", rgb, BLACK);
    end
    read_pixel(10'd216, 10'd248, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL write_lower_neighbour trail=%h expected=%h", rgb, BLACK);
    end
    read_pixel(10'd700, 10'd240, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL offscreen_pixel trail=%h expected=%h", rgb, BLACK);
    end
  endtask

  task automatic test_same_cell();
    logic [23:0] rgb;
    do_step(10'd219, 10'd245);
    @(negedge CLOCK_50);
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL same_cell_early collision=%b expected=0", collision);
    end
    @(negedge CLOCK_50);
    checks++;
    if (collision !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL same_cell_hit collision=%b busy=%b expected collision=1 busy=0", collision, busy);
    end
    do_step(10'd300, 10'd300);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dead_step_busy busy=%b expected=0", busy);
    end
    repeat (3) @(negedge CLOCK_50);
    read_pixel(10'd300, 10'd300, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL dead_step_no_write trail=%h expected=%h", rgb, BLACK);
    end
  endtask

  task automatic test_clear();
    logic [23:0] rgb;
    int n;
    int bad;
    clear = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (collision !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_next_cycle collision=%b busy=%b expected collision=0 busy=1", collision, busy);
    end
    repeat (2) @(negedge CLOCK_50);
    clear = 1'b0;
    wait_sweep(n, bad);
    checks++;
    if (n !== 4800 || bad !== 0) begin
      errors++;
      $display("FAIL clear_held_sweep busy_cycles=%0d bad=%0d expected 4800 and 0", n, bad);
    end
    read_pixel(10'd216, 10'd240, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL clear_wiped trail=%h expected=%h", rgb, BLACK);
    end
  endtask

  task automatic test_out_of_bounds();
    logic [23:0] rgb;
    do_step(10'd8, 10'd240);
    checks++;
    if (collision !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oob_left collision=%b busy=%b expected collision=1 busy=0", collision, busy);
    end
    read_pixel(10'd8, 10'd240, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL oob_no_write trail=%h expected=%h", rgb, BLACK);
    end
    pulse_clear_and_sweep("oob1");
    do_step(10'd624, 10'd240);
    checks++;
    if (collision !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oob_right collision=%b busy=%b expected collision=1 busy=0", collision, busy);
    end
    pulse_clear_and_sweep("oob2");
    do_step(10'd623, 10'd463);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL corner_legal collision=%b expected=0", collision);
    end
    read_pixel(10'd620, 10'd460, rgb);
    checks++;
    if (rgb !== TRAIL) begin
      errors++;
      $display("FAIL corner_written trail=%h expected=%h", rgb, TRAIL);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] rgb;
    head_x = 10'd216;
    head_y = 10'd240;
    step   = 1'b1;
    @(negedge CLOCK_50);
    head_x = 10'd300;
    head_y = 10'd300;
    @(negedge CLOCK_50);
    step = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL b2b_state busy=%b collision=%b expected busy=0 collision=0", busy, collision);
    end
    read_pixel(10'd300, 10'd300, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL b2b_second_ignored trail=%h expected=%h", rgb, BLACK);
    end
    read_pixel(10'd216, 10'd240, rgb);
    checks++;
    if (rgb !== TRAIL) begin
      errors++;
      $display("FAIL b2b_first_written trail=%h expected=%h", rgb, TRAIL);
    end
  endtask

  task automatic test_clear_abort();
    logic [23:0] rgb;
    int n;
    int bad;
    do_step(10'd400, 10'd400);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    wait_sweep(n, bad);
    checks++;
    if (n !== 4800 || bad !== 0) begin
      errors++;
      $display("FAIL abort_sweep busy_cycles=%0d bad=%0d expected 4800 and 0", n, bad);
    end
    read_pixel(10'd216, 10'd240, rgb);
    checks++;
    if (rgb !== BLACK) begin
      errors++;
      $display("FAIL abort_wiped trail=%h expected=%h", rgb, BLACK);
    end
    do_step(10'd400, 10'd400);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_write collision=%b expected=0", collision);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_same_cell();
    test_clear();
    test_out_of_bounds();
    test_back_to_back();
    test_clear_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
